gpio_bank: RTL and testbench
============================

GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 8, meaning number of independent GPIO pins (2..32).
REQ-002 SHALL have parameter PULSE_W, default 10, meaning pulse-count width in clk_en ticks.
REQ-003 SHALL have port clk  in  1  meaning the single clock.
REQ-004 SHALL have port async_rst  in  1  meaning asynchronous active-high reset.
REQ-005 SHALL have port clk_en  in  1  meaning the tick qualifier; all state except reset advances only when high.
REQ-006 SHALL have port CmdValid  in  1 and port CmdReady  out  1, meaning the command handshake.
REQ-007 SHALL have port CmdOp  in  3  meaning the opcode (REQ-013).
REQ-008 SHALL have port CmdChannel  in  clog2(CHANNELS)  meaning the target pin.
REQ-009 SHALL have port CmdData  in  PULSE_W  meaning the operand.
REQ-010 SHALL have ports RespValid  out  1, RespReady  in  1 and RespData  out  4, meaning the READ response.
REQ-011 SHALL have ports IODataIn  in  CHANNELS, IODataOut  out  CHANNELS and IODataOutEn  out  CHANNELS, meaning the pad side.
REQ-012 SHALL have ports PinDataIn  out  CHANNELS (synchronised pad levels) and Irq  out  1.

Function
REQ-013 SHALL decode CmdOp as 000 SET, 001 CLEAR, 010 PULSE, 011 READ, 100 IRQ_CFG, 101 IRQ_ACK; 110 and 111 SHALL be accepted as no-ops.
REQ-014 SHALL accept a command only when CmdValid && CmdReady && clk_en; CmdReady = ~RespValid || RespReady.
REQ-015 SHALL, on CmdChannel >= CHANNELS, accept the command with no state change; a READ SHALL then return 0.
REQ-016 SHALL, on SET, load the pin level with CmdData[0] and set the enable; pad outputs change on the 2nd clk_en tick after acceptance (decode register, then output register).
REQ-017 SHALL, on CLEAR, zero the level and the enable and abort any active pulse, all in the same tick.
REQ-018 SHALL, on PULSE with N = CmdData != 0, invert the driven level and force the enable for exactly N clk_en ticks at the pad; N = 0 SHALL be a no-op.
REQ-019 SHALL, on PULSE while a pulse is already busy, restart the count at the new N with no idle gap.
REQ-020 SHALL drive pulse counter state as {busy, count[PULSE_W-1:0]}; busy clears on the tick count reaches 1 and never wraps through 0.
REQ-021 SHALL, if SET and a pulse coincide on a pin, give the SET precedence for level and enable; the pulse SHALL continue to invert the new level.
REQ-022 SHALL pass each IODataIn bit through a 2-flop synchroniser advanced by clk_en; PinDataIn SHALL reflect a pad change after 2 ticks.
REQ-023 SHALL, on READ, set RespValid on the next tick with RespData = {irq_flag, busy, enable, PinDataIn[ch]}; RespValid SHALL hold until RespReady.

Reset
REQ-024 SHALL, while async_rst is high, force IODataOut, IODataOutEn, PinDataIn, RespValid, RespData, Irq and all counters, flags and masks to 0 immediately, independent of clk and clk_en.
REQ-025 SHALL, on reset asserted mid-pulse, deliver no residual pulse after release; the first command after release SHALL be accepted normally.

Configuration
REQ-026 SHALL, with GPIO_BANK_EDGE_IRQ_EN defined, compile per-pin rise/fall enables, sticky edge flags and Irq.
REQ-027 SHALL, with the macro defined, make IRQ_CFG load {fall_en, rise_en} = CmdData[1:0], make IRQ_ACK clear the flag, and drive Irq = OR of the flags.
REQ-028 SHALL, with the macro defined, detect an edge on the synchronised value versus its previous tick; an edge coinciding with IRQ_ACK SHALL leave the flag set.
REQ-029 SHALL, without the macro, treat IRQ_CFG and IRQ_ACK as no-ops, tie Irq to 0, read RespData[3] as 0, and instantiate no flag storage.

Structure
REQ-030 SHALL define the opcode enum, the RespData field positions and the width helper in shared package gpio_pkg.
REQ-031 SHALL instantiate per-channel state (level, enable, pulse counter, synchroniser, edge logic) as sub-module gpio_bank_channel, generated CHANNELS times.
REQ-032 SHALL contain command decode, the response register and the Irq reduction only in the top level.

Verification
REQ-033 SHALL cover: SET ch3 data=1 -> IODataOut[3]=1 and IODataOutEn[3]=1 on the 2nd tick; other pins remain 0.
REQ-034 SHALL cover: SET ch0=0 then PULSE ch0 N=5 -> IODataOut[0]=1 for exactly 5 ticks, then 0; busy reads 1 during the pulse and 0 after.
REQ-035 SHALL cover: PULSE ch1 N=10, then PULSE N=3 at tick 4 -> total high time of 7 ticks; CLEAR mid-pulse -> pad enable drops within 2 ticks.
REQ-036 SHALL cover: READ with RespReady=0 for 3 cycles -> RespValid and RespData stable, CmdReady=0 throughout; next command accepted after the handshake.
REQ-037 SHALL cover (macro defined): IRQ_CFG ch2 rise, pad 0->1 -> Irq=1 by tick 3; IRQ_ACK together with a new edge -> Irq stays 1.
REQ-038 SHALL cover: async_rst pulsed mid-pulse between clock edges -> all outputs 0 immediately; no pulse resumes after release.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg: opcodes, READ response field positions and the channel-index width helper
// shared by gpio_bank and gpio_bank_channel.
package gpio_pkg;
    typedef enum logic [2:0] {
        OP_SET     = 3'd0,
        OP_CLEAR   = 3'd1,
        OP_PULSE   = 3'd2,
        OP_READ    = 3'd3,
        OP_IRQ_CFG = 3'd4,
        OP_IRQ_ACK = 3'd5,
        OP_NOP6    = 3'd6,
        OP_NOP7    = 3'd7
    } gpio_op_e;

    localparam int RESP_PIN  = 0;
    localparam int RESP_EN   = 1;
    localparam int RESP_BUSY = 2;
    localparam int RESP_IRQ  = 3;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/gpio_bank_channel.sv
// gpio_bank_channel: one pin's level/enable, pulse counter, 2-flop input synchroniser and,
// with GPIO_BANK_EDGE_IRQ_EN defined, rise/fall enables plus a sticky edge flag.
module gpio_bank_channel
    import gpio_pkg::*;
#(
    parameter int PULSE_W = 10
) (
    input  logic               clk,
    input  logic               async_rst,
    input  logic               clk_en,
    input  logic               cmd_valid,
    input  gpio_op_e           cmd_op,
    input  logic [PULSE_W-1:0] cmd_data,
    input  logic               pad_in,
    output logic               pad_out,
    output logic               pad_oe,
    output logic               pin,
    output logic               busy,
    output logic               enable,
    output logic               irq_flag
);
    logic               level;
    logic [PULSE_W-1:0] count;
    logic [1:0]         sync;
    logic               set, clr, pulse;

    assign set   = cmd_valid && cmd_op == OP_SET;
    assign clr   = cmd_valid && cmd_op == OP_CLEAR;
    assign pulse = cmd_valid && cmd_op == OP_PULSE && |cmd_data;

    // busy always implies count >= 1, so stepping down from 1 ends the pulse without wrapping
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            level  <= 1'b0;
            enable <= 1'b0;
            busy   <= 1'b0;
            count  <= '0;
            sync   <= '0;
        end else if (clk_en) begin
            sync <= {sync[0], pad_in};
            if (clr) begin
                level  <= 1'b0;
                enable <= 1'b0;
                busy   <= 1'b0;
                count  <= '0;
            end else begin
                if (set) begin
                    level  <= cmd_data[0];
                    enable <= 1'b1;
                end
                if (pulse) begin
                    busy  <= 1'b1;
                    count <= cmd_data;
                end else if (busy) begin
                    busy  <= count != PULSE_W'(1);
                    count <= count - 1'b1;
                end
            end
        end
    end

    assign pin     = sync[1];
    assign pad_out = level ^ busy;
    assign pad_oe  = enable | busy;

`ifdef GPIO_BANK_EDGE_IRQ_EN
    logic rise_en, fall_en, prev, flag, cfg, ack;

    assign cfg = cmd_valid && cmd_op == OP_IRQ_CFG;
    assign ack = cmd_valid && cmd_op == OP_IRQ_ACK;

    // a fresh edge wins over a simultaneous acknowledge
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            rise_en <= 1'b0;
            fall_en <= 1'b0;
            prev    <= 1'b0;
            flag    <= 1'b0;
        end else if (clk_en) begin
            prev <= sync[1];
            if (cfg)
                {fall_en, rise_en} <= cmd_data[1:0];
            flag <= (flag & ~ack) | (rise_en & sync[1] & ~prev) | (fall_en & ~sync[1] & prev);
        end
    end

    assign irq_flag = flag;
`else
    assign irq_flag = 1'b0;
`endif
endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: command decode register, READ response register and Irq reduction over
// CHANNELS gpio_bank_channel instances; edge interrupts exist only with GPIO_BANK_EDGE_IRQ_EN.
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int PULSE_W  = 10
) (
    input  logic                        clk,
    input  logic                        async_rst,
    input  logic                        clk_en,
    input  logic                        CmdValid,
    output logic                        CmdReady,
    input  logic [2:0]                  CmdOp,
    input  logic [ch_w(CHANNELS)-1:0]   CmdChannel,
    input  logic [PULSE_W-1:0]          CmdData,
    output logic                        RespValid,
    input  logic                        RespReady,
    output logic [3:0]                  RespData,
    input  logic [CHANNELS-1:0]         IODataIn,
    output logic [CHANNELS-1:0]         IODataOut,
    output logic [CHANNELS-1:0]         IODataOutEn,
    output logic [CHANNELS-1:0]         PinDataIn,
    output logic                        Irq
);
    localparam int CW = ch_w(CHANNELS);

    logic                dec_valid;
    gpio_op_e            dec_op;
    logic [CW-1:0]       dec_ch;
    logic [PULSE_W-1:0]  dec_data;
    logic [CHANNELS-1:0] ch_busy, ch_en, ch_flag;
    logic                accept;
    logic [3:0]          rd;

    assign CmdReady = ~RespValid | RespReady;
    assign accept   = CmdValid && CmdReady && clk_en;

    // out-of-range channels read back as all zeros
    always_comb begin
        rd = '0;
        if (32'(CmdChannel) < CHANNELS) begin
            rd[RESP_PIN]  = PinDataIn[CmdChannel];
            rd[RESP_EN]   = ch_en[CmdChannel];
            rd[RESP_BUSY] = ch_busy[CmdChannel];
            rd[RESP_IRQ]  = ch_flag[CmdChannel];
        end
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            dec_valid <= 1'b0;
            dec_op    <= OP_SET;
            dec_ch    <= '0;
            dec_data  <= '0;
            RespValid <= 1'b0;
            RespData  <= '0;
        end else if (clk_en) begin
            dec_valid <= accept;
            dec_op    <= gpio_op_e'(CmdOp);
            dec_ch    <= CmdChannel;
            dec_data  <= CmdData;
            if (accept && gpio_op_e'(CmdOp) == OP_READ) begin
                RespValid <= 1'b1;
                RespData  <= rd;
            end else if (RespReady) begin
                RespValid <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        gpio_bank_channel #(.PULSE_W(PULSE_W)) u_ch (
            .clk       (clk),
            .async_rst (async_rst),
            .clk_en    (clk_en),
            .cmd_valid (dec_valid && 32'(dec_ch) == i),
            .cmd_op    (dec_op),
            .cmd_data  (dec_data),
            .pad_in    (IODataIn[i]),
            .pad_out   (IODataOut[i]),
            .pad_oe    (IODataOutEn[i]),
            .pin       (PinDataIn[i]),
            .busy      (ch_busy[i]),
            .enable    (ch_en[i]),
            .irq_flag  (ch_flag[i])
        );
    end

    assign Irq = |ch_flag;
endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed and randomized stimulus for gpio_bank, checked against a
// per-pin model of levels, remaining pulse ticks, synchronised pads and edge flags.
module tb_gpio_bank;
    localparam int CH = 6;
    localparam int PW = 10;
    localparam int CW = 3;
`ifdef GPIO_BANK_EDGE_IRQ_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic          clk = 1'b0, async_rst = 1'b1, clk_en = 1'b1;
    logic          CmdValid = 1'b0, RespReady = 1'b1;
    logic [2:0]    CmdOp = '0;
    logic [CW-1:0] CmdChannel = '0;
    logic [PW-1:0] CmdData = '0;
    logic          CmdReady, RespValid, Irq;
    logic [3:0]    RespData;
    logic [CH-1:0] IODataIn = '0, IODataOut, IODataOutEn, PinDataIn;
    int            checks = 0, failures = 0, hi;

    bit            lvl[CH], en[CH], rise[CH], fall[CH], flg[CH];
    int            rem[CH];
    logic [CH-1:0] s1, pin_m, pin_prev;
    bit            m_rv, p_valid;
    logic [3:0]    m_rd;
    int            p_op, p_ch, p_data;

    gpio_bank #(.CHANNELS(CH), .PULSE_W(PW)) dut (
        .clk(clk), .async_rst(async_rst), .clk_en(clk_en),
        .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdOp(CmdOp),
        .CmdChannel(CmdChannel), .CmdData(CmdData),
        .RespValid(RespValid), .RespReady(RespReady), .RespData(RespData),
        .IODataIn(IODataIn), .IODataOut(IODataOut), .IODataOutEn(IODataOutEn),
        .PinDataIn(PinDataIn), .Irq(Irq)
    );

    always #5 clk = ~clk;

    task automatic mreset();
        for (int c = 0; c < CH; c++) begin
            lvl[c] = 0; en[c] = 0; rise[c] = 0; fall[c] = 0; flg[c] = 0; rem[c] = 0;
        end
        s1 = '0; pin_m = '0; pin_prev = '0;
        m_rv = 0; m_rd = '0; p_valid = 0;
    endtask

    function automatic logic [3:0] m_read(int ch);
        if (ch >= CH) return 4'h0;
        return {flg[ch], rem[ch] > 0, en[ch], pin_m[ch]};
    endfunction

    function automatic logic [CH-1:0] m_out();
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) r[c] = lvl[c] ^ (rem[c] > 0);
        return r;
    endfunction

    function automatic logic [CH-1:0] m_oe();
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) r[c] = en[c] || rem[c] > 0;
        return r;
    endfunction

    function automatic bit m_irq();
        bit r = 0;
        for (int c = 0; c < CH; c++) r |= flg[c];
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, "/out"}, IODataOut, m_out());
        chk({tag, "/oe"}, IODataOutEn, m_oe());
        chk({tag, "/pin"}, PinDataIn, pin_m);
        chk({tag, "/rvalid"}, RespValid, m_rv);
        chk({tag, "/rdata"}, RespData, m_rd);
        chk({tag, "/irq"}, Irq, m_irq());
        chk({tag, "/cready"}, CmdReady, !m_rv || RespReady);
    endtask

    // one clock edge: the command decoded last tick takes effect, this tick's command is queued
    task automatic step();
        bit acc;
        logic [3:0] rd;
        acc = CmdValid && (!m_rv || RespReady) && clk_en;
        rd = m_read(int'(CmdChannel));
        @(posedge clk);
        #1;
        if (async_rst) mreset();
        else if (clk_en) begin
            for (int c = 0; c < CH; c++) begin
                bit hit, up, dn;
                hit = p_valid && p_ch == c;
                up = pin_m[c] && !pin_prev[c];
                dn = !pin_m[c] && pin_prev[c];
                flg[c] = (flg[c] && !(hit && p_op == 5)) || (rise[c] && up) || (fall[c] && dn);
`ifdef GPIO_BANK_EDGE_IRQ_EN
                if (hit && p_op == 4) begin
                    rise[c] = p_data[0];
                    fall[c] = p_data[1];
                end
`endif
                if (hit && p_op == 2 && p_data != 0) rem[c] = p_data;
                else if (rem[c] > 0) rem[c]--;
                if (hit && p_op == 0) begin
                    lvl[c] = p_data[0];
                    en[c] = 1;
                end
                if (hit && p_op == 1) begin
                    lvl[c] = 0; en[c] = 0; rem[c] = 0;
                end
            end
            if (acc && CmdOp == 3'd3) begin
                m_rv = 1;
                m_rd = rd;
            end else if (RespReady) m_rv = 0;
            pin_prev = pin_m; pin_m = s1; s1 = IODataIn;
            p_valid = acc; p_op = int'(CmdOp); p_ch = int'(CmdChannel); p_data = int'(CmdData);
        end
    endtask

    task automatic cmd(int op, int ch, int data);
        CmdValid = 1'b1; CmdOp = 3'(op); CmdChannel = CW'(ch); CmdData = PW'(data);
        step();
        check_all("cmd");
        CmdValid = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            step();
            check_all("idle");
        end
    endtask

    initial begin
        mreset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        async_rst = 1'b0;
        idle(2);

        // SET ch3 = 1 reaches the pad on the second tick
        cmd(0, 3, 1);
        chk("set3_t1", IODataOut, 0);
        step(); check_all("set3");
        chk("set3_out", IODataOut, 6'h08);
        chk("set3_oe", IODataOutEn, 6'h08);

        // PULSE ch0 N=5 over level 0
        cmd(0, 0, 0);
        cmd(2, 0, 5);
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin
                cmd(3, 0, 0);
                chk("busy_during", RespData[2], 1);
            end else begin
                step(); check_all("pulse5");
            end
            hi += int'(IODataOut[0]);
        end
        chk("pulse5_len", hi, 5);
        cmd(3, 0, 0);
        chk("busy_after", RespData[2], 0);

        // PULSE ch1 N=10 restarted with N=3 on its 4th high tick
        hi = 0;
        cmd(2, 1, 10);
        repeat (3) begin
            step(); check_all("restart");
            hi += int'(IODataOut[1]);
        end
        cmd(2, 1, 3);
        hi += int'(IODataOut[1]);
        repeat (10) begin
            step(); check_all("restart");
            hi += int'(IODataOut[1]);
        end
        chk("restart_len", hi, 7);

        // CLEAR mid-pulse
        cmd(2, 2, 20);
        idle(3);
        chk("clr_pre_oe", IODataOutEn[2], 1);
        cmd(1, 2, 0);
        step(); check_all("clear");
        chk("clr_oe", IODataOutEn[2], 0);
        chk("clr_out", IODataOut[2], 0);

        // READ held by RespReady=0 while a SET waits
        RespReady = 1'b0;
        cmd(3, 3, 0);
        CmdValid = 1'b1; CmdOp = 3'd0; CmdChannel = 3'd4; CmdData = 10'd1;
        repeat (3) begin
            step(); check_all("hold");
            chk("hold_rvalid", RespValid, 1);
            chk("hold_cready", CmdReady, 0);
            chk("hold_data", RespData, 4'h2);
        end
        RespReady = 1'b1;
        step(); check_all("handshake");
        CmdValid = 1'b0;
        idle(2);
        chk("after_hs", IODataOut[4], 1);

        // out-of-range channels change nothing and read as 0
        cmd(0, 7, 1);
        cmd(2, 6, 4);
        idle(2);
        chk("oor_out", IODataOut, 6'h08 | 6'h10);
        cmd(3, 6, 0);
        chk("oor_read", RespData, 0);

        // edge interrupt on ch2
        cmd(4, 2, 1);
        step(); check_all("irq");
        IODataIn[2] = 1'b1;
        idle(3);
        chk("irq_rise", Irq, EDGE);
        cmd(3, 2, 0);
        chk("irq_read", RespData[3], EDGE);
        IODataIn[2] = 1'b0;
        idle(4);
        IODataIn[2] = 1'b1;
        step(); check_all("irq");
        cmd(5, 2, 0);
        step(); check_all("irq");
        chk("irq_ack_edge", Irq, EDGE);
        cmd(5, 2, 0);
        step(); check_all("irq");
        chk("irq_ack", Irq, 0);

        // async reset between edges mid-pulse
        cmd(2, 5, 50);
        idle(3);
        chk("rst_pre", IODataOut[5], 1);
        #3;
        async_rst = 1'b1;
        #1;
        mreset();
        check_all("rst_imm");
        chk("rst_oe", IODataOutEn, 0);
        step(); check_all("rst_hold");
        async_rst = 1'b0;
        idle(10);
        chk("rst_nopulse", IODataOut[5], 0);
        cmd(0, 1, 1);
        step(); check_all("post_rst");
        chk("post_rst_set", IODataOut[1], 1);

        // randomized traffic with gated ticks and back-pressure
        for (int i = 0; i < 400; i++) begin
            clk_en = ($urandom_range(3) != 0);
            RespReady = ($urandom_range(2) != 0);
            if ($urandom_range(3) == 0) IODataIn = CH'($urandom);
            CmdValid = $urandom_range(1);
            CmdOp = 3'($urandom_range(7));
            CmdChannel = CW'($urandom_range(7));
            CmdData = PW'($urandom_range(12));
            step();
            check_all("rand");
        end
        clk_en = 1'b1;
        CmdValid = 1'b0;
        RespReady = 1'b1;
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
